// File: rtl/minirisc_run_monitor.sv
// Reset sequencer and run monitor for KGPminiRISC; all outputs registered (1-cycle), no backpressure.
// Optional PC trace signature enabled by defining MONITOR_SIGNATURE_EN.
module minirisc_run_monitor #(
  parameter int PC_W        = 32,
  parameter int CNT_W       = 32,
  parameter int RST_CYCLES  = 5,
  parameter int HALT_CYCLES = 4,
  parameter int MAX_CYCLES  = 100000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [PC_W-1:0]  i_pc,
  input  logic [1:0]       i_reg_write,
  input  logic             i_dmem_write_enable,
  output logic             o_core_rst,
  output logic             o_running,
  output logic             o_done,
  output logic             o_halted,
  output logic             o_timeout,
  output logic [CNT_W-1:0] o_cycle_count,
  output logic [CNT_W-1:0] o_regwr_count,
  output logic [CNT_W-1:0] o_memwr_count,
  output logic [PC_W-1:0]  o_signature
);

  localparam int HOLD_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int STUCK_W = (HALT_CYCLES > 1) ? $clog2(HALT_CYCLES) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RST_CYCLES - 1);
  localparam logic [STUCK_W-1:0] STUCK_HALT = STUCK_W'(HALT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CYC_LAST   = CNT_W'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RESET_HOLD, RUN, DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic [HOLD_W-1:0]  r_hold, w_hold_nxt;
  logic [STUCK_W-1:0] r_stuck, w_stuck_nxt;
  logic               r_first, w_first_nxt;
  logic [PC_W-1:0]    r_prev_pc;
  logic [CNT_W-1:0]   r_cycle, w_cycle_nxt;
  logic [CNT_W-1:0]   r_regwr, w_regwr_nxt;
  logic [CNT_W-1:0]   r_memwr, w_memwr_nxt;
  logic               r_halted, w_halted_nxt;
  logic               r_timeout, w_timeout_nxt;
  logic               r_core_rst, r_running, r_done;
  logic               w_clear, w_run_cycle, w_halt_hit, w_to_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    w_state_nxt   = r_state;
    w_hold_nxt    = r_hold;
    w_stuck_nxt   = r_stuck;
    w_first_nxt   = r_first;
    w_cycle_nxt   = r_cycle;
    w_regwr_nxt   = r_regwr;
    w_memwr_nxt   = r_memwr;
    w_halted_nxt  = r_halted;
    w_timeout_nxt = r_timeout;
    w_clear       = 1'b0;
    w_run_cycle   = 1'b0;
    w_halt_hit    = 1'b0;
    w_to_hit      = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (i_start) begin
          w_state_nxt   = RESET_HOLD;
          w_clear       = 1'b1;
          w_hold_nxt    = '0;
          w_stuck_nxt   = '0;
          w_cycle_nxt   = '0;
          w_regwr_nxt   = '0;
          w_memwr_nxt   = '0;
          w_halted_nxt  = 1'b0;
          w_timeout_nxt = 1'b0;
        end
      end
      RESET_HOLD: begin
        if (r_hold == HOLD_LAST) begin
          w_state_nxt = RUN;
          w_hold_nxt  = '0;
          w_first_nxt = 1'b1;
        end else begin
          w_hold_nxt = r_hold + HOLD_W'(1);
        end
      end
      RUN: begin
        w_run_cycle = 1'b1;
        w_first_nxt = 1'b0;
        w_cycle_nxt = sat_inc(r_cycle);
        if (i_reg_write != 2'b00) w_regwr_nxt = sat_inc(r_regwr);
        if (i_dmem_write_enable)  w_memwr_nxt = sat_inc(r_memwr);
        // No previous PC exists on the first RUN cycle, so it never counts as stuck.
        if (!r_first && (i_pc == r_prev_pc)) w_stuck_nxt = r_stuck + STUCK_W'(1);
        else                                 w_stuck_nxt = '0;
        w_halt_hit = (w_stuck_nxt == STUCK_HALT);
        w_to_hit   = (r_cycle == CYC_LAST) && !(&r_cycle);
        if (w_halt_hit) w_halted_nxt = 1'b1;
        if (w_to_hit)   w_timeout_nxt = 1'b1;
        if (w_halt_hit || w_to_hit) w_state_nxt = DONE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_hold     <= '0;
      r_stuck    <= '0;
      r_first    <= 1'b0;
      r_prev_pc  <= '0;
      r_cycle    <= '0;
      r_regwr    <= '0;
      r_memwr    <= '0;
      r_halted   <= 1'b0;
      r_timeout  <= 1'b0;
      r_core_rst <= 1'b1;
      r_running  <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold     <= w_hold_nxt;
      r_stuck    <= w_stuck_nxt;
      r_first    <= w_first_nxt;
      if (w_run_cycle) r_prev_pc <= i_pc;
      r_cycle    <= w_cycle_nxt;
      r_regwr    <= w_regwr_nxt;
      r_memwr    <= w_memwr_nxt;
      r_halted   <= w_halted_nxt;
      r_timeout  <= w_timeout_nxt;
      r_core_rst <= (w_state_nxt != RUN);
      r_running  <= (w_state_nxt == RUN);
      r_done     <= (w_state_nxt == DONE);
    end
  end

`ifdef MONITOR_SIGNATURE_EN
  logic [PC_W-1:0] r_sig;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)            r_sig <= '0;
    else if (w_clear)     r_sig <= '0;
    else if (w_run_cycle) r_sig <= {r_sig[PC_W-2:0], r_sig[PC_W-1]} ^ i_pc;
  end

  assign o_signature = r_sig;
`else
  assign o_signature = '0;
`endif

  assign o_core_rst    = r_core_rst;
  assign o_running     = r_running;
  assign o_done        = r_done;
  assign o_halted      = r_halted;
  assign o_timeout     = r_timeout;
  assign o_cycle_count = r_cycle;
  assign o_regwr_count = r_regwr;
  assign o_memwr_count = r_memwr;

endmodule

// File: tb/tb_minirisc_run_monitor.sv
// Directed bench for minirisc_run_monitor: a transaction-level model compared every cycle, plus literal checks.
module tb_minirisc_run_monitor;

  localparam int PC_W        = 8;
  localparam int CNT_W       = 8;
  localparam int RST_CYCLES  = 5;
  localparam int HALT_CYCLES = 4;
  localparam int MAX_CYCLES  = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [PC_W-1:0]   pc = '0;
  logic [1:0]        reg_write = 2'b00;
  logic              dmem_we = 1'b0;
  logic              core_rst, running, done, halted, timeout;
  logic [CNT_W-1:0]  cycle_count, regwr_count, memwr_count;
  logic [PC_W-1:0]   signature;

  int n_checks = 0;
  int n_errors = 0;

  minirisc_run_monitor #(
    .PC_W(PC_W), .CNT_W(CNT_W), .RST_CYCLES(RST_CYCLES),
    .HALT_CYCLES(HALT_CYCLES), .MAX_CYCLES(MAX_CYCLES)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_pc(pc),
    .i_reg_write(reg_write), .i_dmem_write_enable(dmem_we),
    .o_core_rst(core_rst), .o_running(running), .o_done(done),
    .o_halted(halted), .o_timeout(timeout), .o_cycle_count(cycle_count),
    .o_regwr_count(regwr_count), .o_memwr_count(memwr_count),
    .o_signature(signature)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: mode 0 idle, 1 reset hold, 2 run, 3 done.
  int              m_mode;
  int              m_hold_seen;
  int              m_cyc, m_rw, m_mw;
  bit              m_halted, m_to;
  logic [PC_W-1:0] m_sig;
  logic [PC_W-1:0] m_pcs[$];
  localparam int   CNT_MAX = (1 << CNT_W) - 1;

  task automatic m_clear_run();
    m_cyc = 0; m_rw = 0; m_mw = 0;
    m_halted = 1'b0; m_to = 1'b0; m_sig = '0;
    m_pcs.delete();
  endtask

  task automatic m_reset();
    m_mode = 0; m_hold_seen = 0;
    m_clear_run();
  endtask

  task automatic m_step();
    bit same;
    if (rst) begin
      m_reset();
      return;
    end
    case (m_mode)
      0, 3: if (start) begin
        m_mode = 1;
        m_hold_seen = 0;
        m_clear_run();
      end
      1: begin
        m_hold_seen++;
        if (m_hold_seen == RST_CYCLES) m_mode = 2;
      end
      2: begin
        if (m_cyc == MAX_CYCLES - 1) m_to = 1'b1;
        if (m_cyc < CNT_MAX) m_cyc++;
        if (reg_write != 2'b00 && m_rw < CNT_MAX) m_rw++;
        if (dmem_we && m_mw < CNT_MAX) m_mw++;
        m_sig = {m_sig[PC_W-2:0], m_sig[PC_W-1]} ^ pc;
        m_pcs.push_back(pc);
        // Halt means the last HALT_CYCLES run PCs are all identical.
        if (m_pcs.size() >= HALT_CYCLES) begin
          same = 1'b1;
          for (int i = m_pcs.size() - HALT_CYCLES; i < m_pcs.size(); i++)
            if (m_pcs[i] != pc) same = 1'b0;
          if (same) m_halted = 1'b1;
        end
        if (m_halted || m_to) m_mode = 3;
      end
      default: m_mode = 0;
    endcase
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      m_step();
    end
  end

  initial begin
    logic [PC_W-1:0] exp_sig;
    forever begin
      @(negedge clk);
`ifdef MONITOR_SIGNATURE_EN
      exp_sig = m_sig;
`else
      exp_sig = '0;
`endif
      chk("m_core_rst", core_rst, (m_mode != 2));
      chk("m_running", running, (m_mode == 2));
      chk("m_done", done, (m_mode == 3));
      chk("m_halted", halted, m_halted);
      chk("m_timeout", timeout, m_to);
      chk("m_cycle_count", cycle_count, m_cyc);
      chk("m_regwr_count", regwr_count, m_rw);
      chk("m_memwr_count", memwr_count, m_mw);
      chk("m_signature", signature, exp_sig);
    end
  end

  task automatic run_cycle(input logic [PC_W-1:0] p, input logic [1:0] rw, input logic we);
    pc = p; reg_write = rw; dmem_we = we;
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_running(output int k);
    k = 0;
    while (!running && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    if (!running) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_running actual=0 required=1 after %0d cycles", k);
    end
  endtask

  logic [PC_W-1:0] halt_pcs [6] = '{8'h00, 8'h04, 8'h08, 8'h08, 8'h08, 8'h08};
  logic [1:0]      rw_tab   [8] = '{2'd1, 2'd0, 2'd2, 2'd0, 2'd3, 2'd0, 2'd0, 2'd1};

  initial begin
    int k;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_core_rst", core_rst, 1);
    chk("rst_running", running, 0);
    chk("rst_done", done, 0);
    chk("rst_cycle_count", cycle_count, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset hold length and core_rst/running alignment
    pulse_start();
    chk("hold_core_rst", core_rst, 1);
    wait_running(k);
    chk("hold_len", k, RST_CYCLES);
    chk("run_core_rst", core_rst, 0);

    // Halt on a self-loop
    foreach (halt_pcs[i]) run_cycle(halt_pcs[i], 2'd1, 1'b0);
    chk("halt_halted", halted, 1);
    chk("halt_done", done, 1);
    chk("halt_timeout", timeout, 0);
    chk("halt_cycles", cycle_count, 6);
    chk("halt_core_rst", core_rst, 1);
    chk("halt_regwr", regwr_count, 6);

    // Restart from DONE clears counts during hold
    pulse_start();
    chk("restart_cycles", cycle_count, 0);
    chk("restart_regwr", regwr_count, 0);
    chk("restart_halted", halted, 0);
    chk("restart_done", done, 0);
    chk("restart_core_rst", core_rst, 1);
    wait_running(k);

    // Write counting, then run on into timeout
    for (int i = 0; i < 8; i++) run_cycle(PC_W'(8'h10 + i), rw_tab[i], (i == 1 || i == 4));
    chk("wr_regwr", regwr_count, 4);
    chk("wr_memwr", memwr_count, 2);
    chk("wr_running", running, 1);
    run_cycle(8'h18, 2'd0, 1'b0);
    chk("to_not_yet", timeout, 0);
    run_cycle(8'h19, 2'd0, 1'b0);
    chk("to_timeout", timeout, 1);
    chk("to_halted", halted, 0);
    chk("to_cycles", cycle_count, MAX_CYCLES);
    chk("to_done", done, 1);

    // Start during RUN is ignored; rst mid-run aborts at once
    pulse_start();
    wait_running(k);
    run_cycle(8'h20, 2'd1, 1'b1);
    start = 1'b1;
    run_cycle(8'h21, 2'd0, 1'b0);
    start = 1'b0;
    chk("ign_running", running, 1);
    chk("ign_cycles", cycle_count, 2);
    #2 rst = 1'b1;
    #1;
    chk("abort_core_rst", core_rst, 1);
    chk("abort_running", running, 0);
    chk("abort_cycles", cycle_count, 0);
    chk("abort_regwr", regwr_count, 0);
    chk("abort_memwr", memwr_count, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // PC signature
    pulse_start();
    wait_running(k);
    run_cycle(8'h01, 2'd0, 1'b0);
    run_cycle(8'h02, 2'd0, 1'b0);
    run_cycle(8'h04, 2'd0, 1'b0);
`ifdef MONITOR_SIGNATURE_EN
    chk("sig_value", signature, m_sig);
`else
    chk("sig_value", signature, 0);
`endif
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

endmodule
